stable_matching_pref_loader: RTL and testbench
==============================================

Name: stable_matching_pref_loader

Overview:
- Sequential front end that collects the R receiver lists and S proposer lists as a beat-per-entry stream over a valid/ready handshake.
- Packs the entries into the flat preference vector consumed by stable_matching_comb on its p_input port.
- Range-checks every entry.
- Holds the assembled vector stable, with a valid flag, until the downstream stage acknowledges it.

Parameters:
- Kr, 10, preferences per receiver (list B); must be >= 1
- Ks, 10, preferences per proposer (list A); must be >= 1
- S, 10, number of proposers; must be >= 2
- R, 10, number of receivers; must be >= 2
- Derived localparams (not overridable):
  - logS = ceil(log2(S)), logR = ceil(log2(R))
  - W = max(logS, logR)
  - GW = R*Kr*logS + S*Ks*logR
  - NR = R*Kr, NT = R*Kr + S*Ks

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins or restarts a load
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  loader accepts a beat this cycle
- in_data  in  W  one preference entry, right-justified
- g  out  GW  packed preference vector, feeds p_input
- g_valid  out  1  g is complete and stable
- g_ack  in  1  downstream has consumed g
- busy  out  1  a load is in progress (LOAD_R or LOAD_S)
- err  out  1  sticky; at least one out-of-range entry in the current load

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; beat counter 0; g all zeros; g_valid, in_ready, busy and err all 0.
- States: IDLE, LOAD_R, LOAD_S, DONE.
- A beat is accepted on a rising edge where in_valid & in_ready.
- in_ready = 1 exactly in LOAD_R and LOAD_S, and is combinational from state only. busy is driven the same way.

Transitions:
- IDLE -> LOAD_R on start. Counter is cleared and err is cleared. g keeps its previous contents.
- LOAD_R -> LOAD_S on the accepted beat with counter = NR-1.
- LOAD_S -> DONE on the accepted beat with counter = NT-1.
- DONE -> IDLE on g_ack. g keeps its value.
- start while in LOAD_R, LOAD_S or DONE: restart in LOAD_R with counter 0 and err cleared. g_valid drops next cycle. start takes priority over an accepted beat or g_ack in the same cycle; that beat is discarded.

Entry placement (counter c; c increments by 1 per accepted beat):
- c < NR (receiver entries):
  - i = c / Kr, j = c % Kr
  - in_data[logS-1:0] is written to g[logS*Kr*i + logS*j +: logS]
  - Valid range is < S.
- c >= NR (proposer entries):
  - d = c - NR, i = d / Ks, j = d % Ks
  - in_data[logR-1:0] is written to g[NR*logS + logR*Ks*i + logR*j +: logR]
  - Valid range is < R.
- Index arithmetic: i/j are kept as nested row/column counters, not dividers. Counter width is ceil(log2(NT)).
- Bits of in_data above the field width must be zero; nonzero upper bits count as out of range.

Range errors:
- An out-of-range entry writes 0 into its field and sets err on the same edge.
- err stays set until the next start or reset. The load still completes normally.

Output timing:
- g_valid = (state == DONE); asserted the cycle after the last beat is accepted.
- g only changes on accepted beats, so it is stable throughout DONE.
- g_ack outside DONE is ignored.
- Reset mid-load: everything returns to reset values immediately; partial data is lost.

Decomposition:
- Shared package stable_matching_pkg holds:
  - the log2 function;
  - the width formulas (logS, logR, GW);
  - the field-offset functions rpref_off(i,j) and spref_off(i,j), shared with the matching engine and its bench so the packing cannot drift.
- Sub-module pref_index_counter: nested row/column counters with a phase flag and terminal-count outputs, parameterised by row length and row count, instantiated once per phase.

Test Plan (S=R=Kr=Ks=4, logS=logR=2, W=2, GW=64, NT=32):
1. Reset -> g=64'h0 and g_valid=in_ready=busy=err=0. Then start, then 32 beats with in_data = c%4 and in_valid held high -> in_ready is 1 for exactly 32 cycles; g_valid rises the cycle after beat 31; g = 64'hE4E4E4E4_E4E4E4E4; err=0.
2. Same load with in_valid toggled 1/0 every cycle -> identical g; g_valid rises 1 cycle after the 32nd accepted beat; idle cycles do not advance the counter.
3. S=3 build (logS=2): beat 0 = 3 -> err=1 and g[1:0]=0; remaining beats in range -> load completes and g_valid=1 with err still 1. Next start -> err=0.
4. start asserted after beat 10, with a valid beat in the same cycle -> that beat is dropped and the counter restarts at 0. 32 further beats are needed before g_valid; the first restarted beat lands in g[1:0].
5. In DONE with g_ack=0 for 20 cycles -> g and g_valid are constant. g_ack=1 -> IDLE next cycle and g_valid=0 with g unchanged. Then start and 32 beats -> the new vector replaces the old one.
6. rst_n driven low asynchronously mid-LOAD_S, between clock edges -> g_valid/in_ready/busy/err go to 0 without waiting for a clock edge, and g=0. Release, then start and 32 beats -> correct vector.

Source files
------------

// File: rtl/stable_matching_pkg.sv
// Shared widths and field offsets for the stable matching engine.
// Loader, engine and benches all pack p_input through these helpers.
package stable_matching_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_R,
    LOAD_S,
    DONE
  } load_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  function automatic int log_s(input int s);
    return clog2(s);
  endfunction

  function automatic int log_r(input int r);
    return clog2(r);
  endfunction

  function automatic int gw(
    input int r, input int kr,
    input int s, input int ks
  );
    return r * kr * clog2(s) + s * ks * clog2(r);
  endfunction

  function automatic int rpref_off(
    input int i, input int j,
    input int kr, input int lgs
  );
    return lgs * kr * i + lgs * j;
  endfunction

  function automatic int spref_off(
    input int i, input int j,
    input int ks, input int lgr,
    input int base
  );
    return base + lgr * ks * i + lgr * j;
  endfunction

endpackage

// File: rtl/stable_matching_pref_loader_if.sv
// Beat stream in, packed preference vector out, with downstream ack.
interface stable_matching_pref_loader_if #(
  parameter int W  = 4,
  parameter int GW = 800
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [GW-1:0] g;
  logic          g_valid;
  logic          g_ack;

  modport slave (
    input  in_valid, in_data, g_ack,
    output in_ready, g, g_valid
  );

  modport master (
    output in_valid, in_data, g_ack,
    input  in_ready, g, g_valid
  );
endinterface

// File: rtl/pref_index_counter.sv
// Nested column/row counter for one list phase of the loader.
// Advances only while its phase is active; tc marks the last entry.
module pref_index_counter
  import stable_matching_pkg::*;
#(
  parameter int ROW_LEN = 4,
  parameter int ROWS    = 4,
  localparam int CW = cw(ROW_LEN),
  localparam int RW = cw(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          phase,
  input  logic          step,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          tc
);

  logic col_tc;

  assign col_tc = (col == CW'(ROW_LEN - 1));
  assign tc     = col_tc && (row == RW'(ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (phase && step) begin
      if (col_tc) begin
        col <= '0;
        row <= tc ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stable_matching_pref_loader.sv
// Streams receiver then proposer preference lists into the packed
// p_input vector, range-checking each entry, and holds it until ack.
module stable_matching_pref_loader
  import stable_matching_pkg::*;
#(
  parameter int Kr = 10,
  parameter int Ks = 10,
  parameter int S  = 10,
  parameter int R  = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic err,
  stable_matching_pref_loader_if.slave bus
);

  localparam int LOG_S = log_s(S);
  localparam int LOG_R = log_r(R);
  localparam int GW    = gw(R, Kr, S, Ks);
  localparam int NR    = R * Kr;
  localparam int GIW   = cw(GW);
  localparam int RCW   = cw(Kr);
  localparam int RRW   = cw(R);
  localparam int SCW   = cw(Ks);
  localparam int SRW   = cw(S);

  localparam logic [31:0] S_LIM = S;
  localparam logic [31:0] R_LIM = R;

  load_state_e state, state_n;

  logic           in_load;
  logic           accept;
  logic           step;
  logic           bad;
  logic [31:0]    data_ext;
  logic [GW-1:0]  g_q;
  logic [GIW-1:0] r_off;
  logic [GIW-1:0] s_off;
  logic [RCW-1:0] r_col;
  logic [RRW-1:0] r_row;
  logic [SCW-1:0] s_col;
  logic [SRW-1:0] s_row;
  logic           r_tc;
  logic           s_tc;

  assign in_load     = (state == LOAD_R) || (state == LOAD_S);
  assign bus.in_ready = in_load;
  assign busy        = in_load;
  assign bus.g_valid = (state == DONE);
  assign bus.g       = g_q;

  assign accept = bus.in_valid && in_load;
  // A beat arriving with start is dropped: the load restarts instead.
  assign step   = accept && !start;

  // Upper bits set push the value past the limit, so one compare suffices.
  assign data_ext = 32'(bus.in_data);
  assign bad = (state == LOAD_R) ? (data_ext >= S_LIM)
                                 : (data_ext >= R_LIM);

  pref_index_counter #(
    .ROW_LEN(Kr),
    .ROWS   (R)
  ) u_rcnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start),
    .phase(state == LOAD_R),
    .step (step),
    .col  (r_col),
    .row  (r_row),
    .tc   (r_tc)
  );

  pref_index_counter #(
    .ROW_LEN(Ks),
    .ROWS   (S)
  ) u_scnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start),
    .phase(state == LOAD_S),
    .step (step),
    .col  (s_col),
    .row  (s_row),
    .tc   (s_tc)
  );

  always_comb begin
    r_off = GIW'(rpref_off(int'(r_row), int'(r_col), Kr, LOG_S));
    s_off = GIW'(spref_off(int'(s_row), int'(s_col), Ks, LOG_R,
                           NR * LOG_S));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (start) begin
      state_n = LOAD_R;
    end else begin
      unique case (state)
        IDLE: state_n = IDLE;
        LOAD_R: if (accept && r_tc) state_n = LOAD_S;
        LOAD_S: if (accept && s_tc) state_n = DONE;
        DONE: if (bus.g_ack) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q <= '0;
    end else if (step) begin
      if (state == LOAD_R) begin
        g_q[r_off +: LOG_S] <=
          bad ? '0 : bus.in_data[LOG_S-1:0];
      end else begin
        g_q[s_off +: LOG_R] <=
          bad ? '0 : bus.in_data[LOG_R-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (start) begin
      err <= 1'b0;
    end else if (step && bad) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stable_matching_pref_loader.sv
// Scoreboard bench: loader A with S=R=Kr=Ks=4, loader B with S=3.
// Expected vectors come from an index-arithmetic reference model.
module tb_stable_matching_pref_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sa = 1'b0, sb = 1'b0;
  logic va = 1'b0, vb = 1'b0;
  logic ka = 1'b0, kb = 1'b0;
  logic [1:0] d = 2'd0;
  logic busy_a, err_a, busy_b, err_b;

  int n_chk = 0;
  int n_pass = 0;

  logic [63:0] qa_g[$];
  logic [63:0] qb_g[$];
  bit          qa_e[$];
  bit          qb_e[$];

  stable_matching_pref_loader_if #(.W(2), .GW(64)) ifa ();
  stable_matching_pref_loader_if #(.W(2), .GW(56)) ifb ();

  assign ifa.in_valid = va;
  assign ifa.in_data  = d;
  assign ifa.g_ack    = ka;
  assign ifb.in_valid = vb;
  assign ifb.in_data  = d;
  assign ifb.g_ack    = kb;

  stable_matching_pref_loader #(
    .Kr(4), .Ks(4), .S(4), .R(4)
  ) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .start(sa),
    .busy (busy_a),
    .err  (err_a),
    .bus  (ifa)
  );

  stable_matching_pref_loader #(
    .Kr(4), .Ks(4), .S(3), .R(4)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .start(sb),
    .busy (busy_b),
    .err  (err_b),
    .bus  (ifb)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(string nm, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, got, exp);
  endtask

  // Reference: entry c goes to row c/K, column c%K of its list.
  function automatic logic [64:0] model(int s, int ents[$]);
    int ls, lr, nr, pos, lim, wd, val;
    logic [63:0] v;
    bit e;
    ls = $clog2(s);
    lr = 2;
    nr = 16;
    v = '0;
    e = 1'b0;
    for (int c = 0; c < ents.size(); c++) begin
      if (c < nr) begin
        pos = ls * 4 * (c / 4) + ls * (c % 4);
        lim = s;
        wd = ls;
      end else begin
        pos = nr * ls + lr * 4 * ((c - nr) / 4)
            + lr * ((c - nr) % 4);
        lim = 4;
        wd = lr;
      end
      val = ents[c];
      if (val >= lim) begin
        val = 0;
        e = 1'b1;
      end
      for (int b = 0; b < wd; b++) v[pos + b] = val[b];
    end
    return {e, v};
  endfunction

  function automatic logic get_rdy(int sel);
    return (sel != 0) ? ifb.in_ready : ifa.in_ready;
  endfunction

  function automatic logic get_gv(int sel);
    return (sel != 0) ? ifb.g_valid : ifa.g_valid;
  endfunction

  function automatic logic get_err(int sel);
    return (sel != 0) ? err_b : err_a;
  endfunction

  function automatic logic get_busy(int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction

  function automatic logic [63:0] get_g(int sel);
    return (sel != 0) ? 64'(ifb.g) : ifa.g;
  endfunction

  task automatic set_v(int sel, logic v);
    if (sel != 0) vb = v;
    else va = v;
  endtask

  task automatic set_s(int sel, logic v);
    if (sel != 0) sb = v;
    else sa = v;
  endtask

  task automatic set_k(int sel, logic v);
    if (sel != 0) kb = v;
    else ka = v;
  endtask

  // Scoreboard monitors: pop on each rising g_valid, then watch hold.
  logic pva = 1'b0, pvb = 1'b0;
  logic [63:0] hga, hgb;

  always @(negedge clk) begin
    if (!rst_n) begin
      pva <= 1'b0;
    end else begin
      if (ifa.g_valid && !pva) begin
        if (qa_g.size() == 0) begin
          chk("a_sb_empty", 64'd1, 64'd0);
        end else begin
          chk("a_g", ifa.g, qa_g.pop_front());
          chk("a_err", 64'(err_a), 64'(qa_e.pop_front()));
        end
      end else if (ifa.g_valid) begin
        chk("a_hold", ifa.g, hga);
      end
      pva <= ifa.g_valid;
      hga <= ifa.g;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pvb <= 1'b0;
    end else begin
      if (ifb.g_valid && !pvb) begin
        if (qb_g.size() == 0) begin
          chk("b_sb_empty", 64'd1, 64'd0);
        end else begin
          chk("b_g", 64'(ifb.g), qb_g.pop_front());
          chk("b_err", 64'(err_b), 64'(qb_e.pop_front()));
        end
      end else if (ifb.g_valid) begin
        chk("b_hold", 64'(ifb.g), hgb);
      end
      pvb <= ifb.g_valid;
      hgb <= 64'(ifb.g);
    end
  end

  // mode 0: c%4, 1: random, 2: first entry 3 then in range for S=3.
  task automatic run_load(int sel, int mode, bit toggle,
                          int abort_at, int stop_at);
    int nt, k, e;
    bit ph, restarted, v, abort;
    int ents[$];
    logic [64:0] m;
    nt = (sel != 0) ? 28 : 32;
    for (int c = 0; c < nt; c++) begin
      if (mode == 0) e = c % 4;
      else if (mode == 1) e = int'($urandom_range(0, 3));
      else if (c == 0) e = 3;
      else if (c < 16) e = int'($urandom_range(0, 2));
      else e = int'($urandom_range(0, 3));
      ents.push_back(e);
    end
    if (stop_at < 0) begin
      m = model((sel != 0) ? 3 : 4, ents);
      if (sel != 0) begin
        qb_g.push_back(m[63:0]);
        qb_e.push_back(m[64]);
      end else begin
        qa_g.push_back(m[63:0]);
        qa_e.push_back(m[64]);
      end
    end
    @(posedge clk); #1;
    set_s(sel, 1'b1);
    @(posedge clk); #1;
    set_s(sel, 1'b0);
    chk("start_err_clr", 64'(get_err(sel)), 64'd0);
    chk("start_busy", 64'(get_busy(sel)), 64'd1);
    k = 0;
    ph = 1'b1;
    restarted = 1'b0;
    while (k < nt && k != stop_at) begin
      v = toggle ? ph : 1'b1;
      ph = !ph;
      abort = (k == abort_at) && !restarted;
      if (abort) v = 1'b1;
      set_v(sel, v);
      if (abort_at >= 0 && !restarted) d = 2'(3 - ents[k]);
      else d = 2'(ents[k]);
      if (abort) set_s(sel, 1'b1);
      @(negedge clk);
      chk("in_ready", 64'(get_rdy(sel)), 64'd1);
      chk("g_valid_early", 64'(get_gv(sel)), 64'd0);
      @(posedge clk); #1;
      if (abort) begin
        set_s(sel, 1'b0);
        k = 0;
        restarted = 1'b1;
      end else if (v) begin
        k++;
      end
    end
    set_v(sel, 1'b0);
    if (stop_at < 0) begin
      @(negedge clk);
      chk("g_valid_rise", 64'(get_gv(sel)), 64'd1);
      chk("in_ready_done", 64'(get_rdy(sel)), 64'd0);
      chk("busy_done", 64'(get_busy(sel)), 64'd0);
    end
  endtask

  task automatic do_ack(int sel, int hold);
    logic [63:0] gs;
    repeat (hold) @(posedge clk);
    #1;
    gs = get_g(sel);
    set_k(sel, 1'b1);
    @(posedge clk); #1;
    set_k(sel, 1'b0);
    chk("ack_gv", 64'(get_gv(sel)), 64'd0);
    chk("ack_g_keep", get_g(sel), gs);
    chk("ack_busy", 64'(get_busy(sel)), 64'd0);
  endtask

  task automatic chk_reset_a();
    chk("rst_g", ifa.g, 64'd0);
    chk("rst_gv", 64'(ifa.g_valid), 64'd0);
    chk("rst_rdy", 64'(ifa.in_ready), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_err", 64'(err_a), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_a();
    chk("rst_b_g", 64'(ifb.g), 64'd0);
    rst_n = 1'b1;

    // Ordered beats, then a toggled-valid repeat of the same load.
    run_load(0, 0, 1'b0, -1, -1);
    chk("t1_g", ifa.g, 64'hE4E4E4E4_E4E4E4E4);
    chk("t1_err", 64'(err_a), 64'd0);
    do_ack(0, 0);
    run_load(0, 0, 1'b1, -1, -1);
    chk("t2_g", ifa.g, 64'hE4E4E4E4_E4E4E4E4);
    do_ack(0, 2);

    // Out-of-range first receiver entry on the S=3 loader.
    run_load(1, 2, 1'b0, -1, -1);
    chk("t3_err", 64'(err_b), 64'd1);
    chk("t3_g0", 64'(ifb.g[1:0]), 64'd0);
    do_ack(1, 1);
    run_load(1, 1, 1'b1, -1, -1);
    do_ack(1, 0);

    // Restart mid-load with a beat in the same cycle.
    run_load(0, 1, 1'b0, 10, -1);
    do_ack(0, 0);

    // Long hold in DONE, then a fresh load replaces the vector.
    run_load(0, 1, 1'b0, -1, -1);
    do_ack(0, 20);
    run_load(0, 1, 1'b1, -1, -1);
    do_ack(0, 0);

    // Asynchronous reset during the proposer phase.
    run_load(0, 1, 1'b0, -1, 20);
    chk("t6_busy_pre", 64'(busy_a), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_a();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      run_load(0, 1, n[0], -1, -1);
      do_ack(0, n);
    end

    repeat (2) @(posedge clk);
    chk("a_sb_drain", 64'(qa_g.size()), 64'd0);
    chk("b_sb_drain", 64'(qb_g.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
